// File: rtl/interrupt_request_register.sv
// interrupt_request_register: IR capture (edge/level) into IRR, IMR masking, ack clear.
// Define IRR_SYNC_EN to put a two-flop synchroniser on each ir line.
module interrupt_request_register #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir,
  input  logic              ltim,
  input  logic              icw1_wr,
  input  logic              ocw1_wr,
  input  logic [NUM_IR-1:0] ocw1_data,
  input  logic              ack_clr,
  input  logic [NUM_IR-1:0] ack_vec,
  output logic [NUM_IR-1:0] irr_raw,
  output logic [NUM_IR-1:0] imr,
  output logic [NUM_IR-1:0] irr_masked,
  output logic              any_req
);
  logic [NUM_IR-1:0] s, s_d, arm, irr, ack, rise, irr_nx, arm_nx;
`ifdef IRR_SYNC_EN
  logic [NUM_IR-1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ir;
      s2 <= s1;
    end
  assign s = s2;
`else
  assign s = ir;
`endif
  // arm re-sets whenever the line is seen low, so an acked edge line must drop before re-requesting
  always_comb begin
    ack    = ack_clr ? ack_vec : '0;
    rise   = ~ack & s & ~s_d & {NUM_IR{~ltim}};
    irr_nx = icw1_wr ? '0 : ~ack & s & (ltim ? '1 : irr | (~s_d & arm));
    arm_nx = icw1_wr ? '1 : (~ack & ~s) | (arm & ~rise);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_d <= '0;
      arm <= '1;
      irr <= '0;
      imr <= '0;
    end else begin
      s_d <= s;
      arm <= arm_nx;
      irr <= irr_nx;
      imr <= icw1_wr ? '0 : ocw1_wr ? ocw1_data : imr;
    end
  assign irr_raw    = irr;
  assign irr_masked = irr & ~imr;
  assign any_req    = |irr_masked;
endmodule

// File: tb/tb_interrupt_request_register.sv
// tb_interrupt_request_register: scoreboard bench with a rule-level IRR/IMR reference model.
module tb_interrupt_request_register;
`ifdef IRR_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  typedef struct packed {
    logic [7:0] irr;
    logic [7:0] imr;
  } exp_t;
  logic       clk = 0, rst_n = 0, ltim = 0, icw1_wr = 0, ocw1_wr = 0, ack_clr = 0;
  logic [7:0] ir = 0, ocw1_data = 0, ack_vec = 0;
  logic [7:0] irr_raw, imr, irr_masked;
  logic       any_req;
  exp_t       q[$];
  logic [7:0] hist[4];
  logic [7:0] m_irr, m_imr, m_arm;
  int         checks = 0, errors = 0;

  interrupt_request_register dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .icw1_wr(icw1_wr),
    .ocw1_wr(ocw1_wr), .ocw1_data(ocw1_data), .ack_clr(ack_clr), .ack_vec(ack_vec),
    .irr_raw(irr_raw), .imr(imr), .irr_masked(irr_masked), .any_req(any_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] highest(input logic [7:0] v);
    logic [7:0] r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 8'(1) << i;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) hist[k] = 0;
    m_irr = 0;
    m_imr = 0;
    m_arm = 8'hFF;
  endtask

  // one clock of stimulus; the model predicts state after the coming rising edge
  task automatic cyc(input logic [7:0] i_ir, input logic i_ltim, input logic i_icw1,
                     input logic i_ocw1, input logic [7:0] od, input logic i_ack,
                     input logic [7:0] av);
    logic s, sd;
    @(negedge clk);
    ir = i_ir; ltim = i_ltim; icw1_wr = i_icw1; ocw1_wr = i_ocw1;
    ocw1_data = od; ack_clr = i_ack; ack_vec = av;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = i_ir;
    for (int b = 0; b < 8; b++) begin
      s = hist[D][b];
      sd = hist[D+1][b];
      if (i_icw1) begin
        m_irr[b] = 0; m_arm[b] = 1;
      end else if (i_ack && av[b]) m_irr[b] = 0;
      else if (!s) begin
        m_irr[b] = 0; m_arm[b] = 1;
      end else if (i_ltim) m_irr[b] = 1;
      else if (!sd && m_arm[b]) begin
        m_irr[b] = 1; m_arm[b] = 0;
      end
    end
    if (i_icw1) m_imr = 0;
    else if (i_ocw1) m_imr = od;
    q.push_back('{m_irr, m_imr});
  endtask

  task automatic hold(input int n, input logic [7:0] i_ir, input logic i_ltim);
    repeat (n) cyc(i_ir, i_ltim, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; ir = 0; icw1_wr = 0; ocw1_wr = 0; ack_clr = 0;
    #1;
    chk("reset_irr_raw", irr_raw, 0);
    chk("reset_imr", imr, 0);
    chk("reset_irr_masked", irr_masked, 0);
    chk("reset_any_req", {7'd0, any_req}, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("irr_raw", irr_raw, e.irr);
        chk("imr", imr, e.imr);
        chk("irr_masked", irr_masked, e.irr & ~e.imr);
        chk("any_req", {7'd0, any_req}, {7'd0, |(e.irr & ~e.imr)});
      end
    end
  end

  initial begin : stim
    logic [7:0] r_ir;
    logic       r_ltim;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    hold(2, 8'h00, 0);
    hold(4, 8'h08, 0);
    hold(4, 8'h28, 0);
    cyc(8'h28, 0, 0, 0, 0, 1, 8'h20);
    hold(3, 8'h28, 0);
    hold(3, 8'h08, 0);
    hold(4, 8'h28, 0);
    cyc(8'h01, 1, 1, 0, 0, 0, 0);
    hold(4, 8'h01, 1);
    cyc(8'h01, 1, 0, 0, 0, 1, 8'h01);
    hold(3, 8'h01, 1);
    cyc(8'hFF, 1, 0, 1, 8'hF0, 0, 0);
    hold(4, 8'hFF, 1);
    cyc(8'hFF, 1, 0, 1, 8'h00, 0, 0);
    hold(2, 8'hFF, 1);
    hold(4, 8'h00, 0);
    hold(2, 8'h04, 0);
    hold(5, 8'h00, 0);
    hold(4, 8'h81, 0);
    cyc(8'h81, 0, 1, 1, 8'hAA, 0, 0);
    hold(4, 8'h81, 0);
    hold(3, 8'h00, 0);
    hold(4, 8'h81, 0);
    r_ir = 0;
    r_ltim = 0;
    for (int n = 0; n < 2000; n++) begin
      logic ak;
      logic [7:0] av;
      r_ir ^= 8'($urandom & $urandom & $urandom);
      if ($urandom_range(199) == 0) r_ltim = ~r_ltim;
      ak = $urandom_range(2) == 0;
      av = ($urandom_range(9) == 0) ? 8'($urandom) : highest(m_irr & ~m_imr);
      cyc(r_ir, r_ltim, $urandom_range(99) == 0, $urandom_range(9) == 0,
          8'($urandom), ak, av);
    end
    hold(2, 8'hFF, 1);
    do_reset();
    hold(5, 8'h3C, 0);
    @(negedge clk);
    ack_clr = 0; icw1_wr = 0; ocw1_wr = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
